// File: rtl/hall_pkg.sv
// hall_pkg
// Shared definitions for the Hall quadrature pattern generator and the
// benches of the angle tracking unit that consume its outputs.
//   DEFAULT_COUNTS_PER_REV : quadrature edges per mechanical revolution
//   state_t                : controller states (IDLE, RUN)
//   hall_encode()          : position[1:0] -> {hall_1, hall_2} phase code
package hall_pkg;

    localparam int DEFAULT_COUNTS_PER_REV = 4024;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Gray-style quadrature sequence: moving up the phase toggles exactly
    // one output per step, with hall_1 leading hall_2.
    function automatic logic [1:0] hall_encode(input logic [1:0] phase);
        logic [1:0] code;
        case (phase)
            2'd0:    code = 2'b00;
            2'd1:    code = 2'b10;
            2'd2:    code = 2'b11;
            default: code = 2'b01;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/hall_pattern_generator_if.sv
// hall_pattern_generator_if
// Move-command handshake between a controller and the pattern generator.
//   cmd_valid     : command present (master -> slave)
//   cmd_ready     : generator idle and able to take a command (slave -> master)
//   cmd_target    : destination position in edge counts
//   cmd_clockwise : 1 = count up, 0 = count down
//   step_div      : edge spacing minus one, in clock cycles
interface hall_pattern_generator_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_target;
    logic        cmd_clockwise;
    logic [15:0] step_div;

    modport master (
        output cmd_valid,
        output cmd_target,
        output cmd_clockwise,
        output step_div,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  cmd_clockwise,
        input  step_div,
        output cmd_ready
    );

endinterface

// File: rtl/hall_step_timer.sv
// hall_step_timer
// Down-counting edge timer. While enabled it counts down once per cycle;
// when it sits at zero it raises tick for that cycle and reloads, so the
// tick period is reload_value + 1 cycles.
//   CLK          : system clock, rising edge
//   reset        : asynchronous, active-low reset (count forced to 0)
//   load         : load load_value (start of a move)
//   load_value   : value used by load
//   clear        : force count to 0 (end of a move)
//   enable       : count/tick permitted this cycle
//   reload_value : value reloaded after each tick
//   tick         : an edge is due this cycle
module hall_step_timer (
    input  logic        CLK,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] reload_value,
    output logic        tick
);

    logic [15:0] count;

    assign tick = enable && (count == 16'd0);

    // load wins over clear because a new move may start the cycle after
    // the previous one finished.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= reload_value;
        end else if (enable) begin
            count <= count - 16'd1;
        end
    end

endmodule

// File: rtl/hall_pattern_generator.sv
// hall_pattern_generator
// Emulates the two Hall quadrature outputs of a rotating encoder. A move
// command steps an internal position toward a target, one edge every
// step_div+1 cycles, wrapping around one revolution of COUNTS_PER_REV edges.
//   CLK              : system clock, rising edge
//   reset            : asynchronous, active-low reset
//   cmd              : command handshake (slave side)
//   stop             : abort the move in progress
//   hall_1, hall_2   : registered quadrature outputs
//   position         : current emulated position in edge counts
//   busy             : a move is in progress
//   done/aborted/err : one-cycle status pulses
module hall_pattern_generator
    import hall_pkg::*;
#(
    parameter int COUNTS_PER_REV = DEFAULT_COUNTS_PER_REV
) (
    input  logic                     CLK,
    input  logic                     reset,
    hall_pattern_generator_if.slave  cmd,
    input  logic                     stop,
    output logic                     hall_1,
    output logic                     hall_2,
    output logic [11:0]              position,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic                     err
);

    // 13 bits so a full 4096-count revolution still compares correctly.
    localparam logic [12:0] CPR_LIMIT = 13'(COUNTS_PER_REV);
    localparam logic [11:0] POS_MAX   = 12'(COUNTS_PER_REV - 1);

    state_t      state;
    state_t      state_next;
    logic [11:0] position_next;
    logic [11:0] pos_step;
    logic [11:0] target_q;
    logic        cw_q;
    logic [15:0] step_div_q;
    logic        done_next;
    logic        aborted_next;
    logic        err_next;
    logic        accept;
    logic        timer_load;
    logic        timer_clear;
    logic        timer_enable;
    logic        timer_tick;

    assign busy          = (state == RUN);
    assign cmd.cmd_ready = (state == IDLE);

    // stop suppresses an edge falling due in the same cycle.
    assign timer_enable = (state == RUN) && !stop;

    hall_step_timer u_timer (
        .CLK          (CLK),
        .reset        (reset),
        .load         (timer_load),
        .load_value   (cmd.step_div),
        .clear        (timer_clear),
        .enable       (timer_enable),
        .reload_value (step_div_q),
        .tick         (timer_tick)
    );

    // Neighbouring position in the latched direction, with wrap-around.
    always_comb begin
        if (cw_q) begin
            pos_step = (position == POS_MAX) ? 12'd0 : position + 12'd1;
        end else begin
            pos_step = (position == 12'd0) ? POS_MAX : position - 12'd1;
        end
    end

    always_comb begin
        state_next    = state;
        position_next = position;
        done_next     = 1'b0;
        aborted_next  = 1'b0;
        err_next      = 1'b0;
        accept        = 1'b0;
        timer_load    = 1'b0;
        timer_clear   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    accept = 1'b1;
                    if ({1'b0, cmd.cmd_target} >= CPR_LIMIT) begin
                        err_next = 1'b1;
                    end else if (cmd.cmd_target == position) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = RUN;
                        timer_load = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_next   = IDLE;
                    aborted_next = 1'b1;
                    timer_clear  = 1'b1;
                end else if (timer_tick) begin
                    position_next = pos_step;
                    if (pos_step == target_q) begin
                        state_next  = IDLE;
                        done_next   = 1'b1;
                        timer_clear = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Hall outputs are encoded from the next position so they change on the
    // same edge as position and never lag it.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            position   <= '0;
            hall_1     <= 1'b0;
            hall_2     <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            err        <= 1'b0;
            target_q   <= '0;
            cw_q       <= 1'b0;
            step_div_q <= '0;
        end else begin
            position         <= position_next;
            {hall_1, hall_2} <= hall_encode(position_next[1:0]);
            done             <= done_next;
            aborted          <= aborted_next;
            err              <= err_next;
            if (accept) begin
                target_q   <= cmd.cmd_target;
                cw_q       <= cmd.cmd_clockwise;
                step_div_q <= cmd.step_div;
            end
        end
    end

endmodule

// File: tb/tb_hall_pattern_generator.sv
// tb_hall_pattern_generator
// Self-checking bench for hall_pattern_generator. A table of moves is applied
// in order; each move pushes its expected edges (position, hall code, cycle)
// into a queue that a negedge monitor pops as the DUT steps. A quadrature
// decoder in the monitor follows the hall outputs and must agree with
// position after every move. Hand-written sequences cover reset, error,
// held-valid and reset-mid-move behaviour.
module tb_hall_pattern_generator;

    localparam int CPR = 4024;

    logic        CLK = 1'b0;
    logic        reset;
    logic        stop;
    logic        hall_1;
    logic        hall_2;
    logic [11:0] position;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        err;

    hall_pattern_generator_if cmd_if ();

    hall_pattern_generator #(
        .COUNTS_PER_REV (CPR)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .cmd      (cmd_if),
        .stop     (stop),
        .hall_1   (hall_1),
        .hall_2   (hall_2),
        .position (position),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int target;
        bit cw;
        int sd;
        int stop_after;
        int exp_pos;
        int exp_done;
        int exp_aborted;
        int exp_err;
    } vec_t;

    typedef struct {
        int         pos;
        logic [1:0] hall;
        int         cyc;
    } edge_t;

    edge_t exp_q[$];
    vec_t  vecs[13];

    int total       = 0;
    int bad         = 0;
    int cycle       = 0;
    int model_pos   = 0;
    int edges_seen  = 0;
    int cnt_done    = 0;
    int cnt_aborted = 0;
    int cnt_err     = 0;
    int angle       = 0;
    int prev_pos    = 0;
    logic [1:0] prev_hall = 2'b00;

    always @(posedge CLK) cycle <= cycle + 1;

    function automatic logic [1:0] expHall(input int p);
        logic [1:0] h;
        case (p % 4)
            0:       h = 2'b00;
            1:       h = 2'b10;
            2:       h = 2'b11;
            default: h = 2'b01;
        endcase
        return h;
    endfunction

    function automatic int phaseOf(input logic [1:0] h);
        int ph;
        case (h)
            2'b00:   ph = 0;
            2'b10:   ph = 1;
            2'b11:   ph = 2;
            default: ph = 3;
        endcase
        return ph;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Edge monitor, pulse counter and quadrature decoder.
    always @(negedge CLK) begin : monitor
        edge_t e;
        int    diff;
        if (!reset) begin
            prev_pos  = position;
            prev_hall = {hall_1, hall_2};
            angle     = 0;
        end else begin
            if (done)    cnt_done++;
            if (aborted) cnt_aborted++;
            if (err)     cnt_err++;
            if ({hall_1, hall_2} != prev_hall) begin
                diff = (phaseOf({hall_1, hall_2}) - phaseOf(prev_hall)) & 3;
                checkOutput("quad_single_toggle", (diff == 1 || diff == 3) ? 1 : 0, 1);
                if (diff == 1)      angle = (angle + 1) % CPR;
                else if (diff == 3) angle = (angle + CPR - 1) % CPR;
                prev_hall = {hall_1, hall_2};
            end
            if (int'(position) != prev_pos) begin
                edges_seen++;
                checkOutput("edge_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("edge_pos", int'(position), e.pos);
                    checkOutput("edge_hall", int'({hall_1, hall_2}), int'(e.hall));
                    checkOutput("edge_cycle", cycle, e.cyc);
                end
                prev_pos = int'(position);
            end
        end
    end

    // Drives one command for one cycle and queues the edges the move
    // should produce. Called at posedge+1 while the DUT is idle.
    task automatic applyStimulus(input vec_t v, input bit with_stop);
        int p;
        int n;
        int acc;
        acc = cycle + 1;
        p   = model_pos;
        n   = 0;
        if (v.target < CPR && v.target != model_pos) begin
            while (p != v.target && (v.stop_after < 0 || n < v.stop_after)) begin
                p = v.cw ? ((p == CPR - 1) ? 0 : p + 1) : ((p == 0) ? CPR - 1 : p - 1);
                n++;
                exp_q.push_back('{p, expHall(p), acc + n * (v.sd + 1)});
            end
        end
        model_pos            = p;
        cmd_if.cmd_valid     = 1'b1;
        cmd_if.cmd_target    = 12'(v.target);
        cmd_if.cmd_clockwise = v.cw;
        cmd_if.step_div      = 16'(v.sd);
        stop                 = with_stop;
        @(posedge CLK); #1;
        cmd_if.cmd_valid = 1'b0;
        stop             = 1'b0;
    endtask

    task automatic waitIdle(input int stop_after, input int e0);
        bit stopped;
        stopped = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (!busy) break;
            if (!stopped && stop_after >= 0 && edges_seen - e0 >= stop_after) begin
                stop    = 1'b1;
                stopped = 1'b1;
            end else begin
                stop = 1'b0;
            end
            @(posedge CLK); #1;
        end
        stop = 1'b0;
        checkOutput("idle_reached", int'(busy), 0);
    endtask

    task automatic runVector(input vec_t v, input bit with_stop, input string tag);
        int d0;
        int a0;
        int r0;
        int e0;
        d0 = cnt_done;
        a0 = cnt_aborted;
        r0 = cnt_err;
        e0 = edges_seen;
        applyStimulus(v, with_stop);
        waitIdle(v.stop_after, e0);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput({tag, "_pos"}, int'(position), v.exp_pos);
        checkOutput({tag, "_hall"}, int'({hall_1, hall_2}), int'(expHall(v.exp_pos)));
        checkOutput({tag, "_done"}, cnt_done - d0, v.exp_done);
        checkOutput({tag, "_aborted"}, cnt_aborted - a0, v.exp_aborted);
        checkOutput({tag, "_err"}, cnt_err - r0, v.exp_err);
        checkOutput({tag, "_pending"}, exp_q.size(), 0);
        checkOutput({tag, "_angle"}, angle, v.exp_pos);
        checkOutput({tag, "_ready"}, int'(cmd_if.cmd_ready), 1);
    endtask

    initial begin : main
        vec_t tv;
        int   d0;
        int   a0;
        int   e0;
        int   acc;

        //          target cw    sd  stop  pos   done ab err
        vecs[0]  = '{8,    1'b1, 3,  -1,   8,    1,   0, 0};
        vecs[1]  = '{2,    1'b0, 1,  -1,   2,    1,   0, 0};
        vecs[2]  = '{4022, 1'b0, 0,  -1,   4022, 1,   0, 0};
        vecs[3]  = '{2,    1'b1, 0,  -1,   2,    1,   0, 0};
        vecs[4]  = '{2,    1'b1, 5,  -1,   2,    1,   0, 0};
        vecs[5]  = '{4024, 1'b1, 0,  -1,   2,    0,   0, 1};
        vecs[6]  = '{4095, 1'b0, 0,  -1,   2,    0,   0, 1};
        vecs[7]  = '{0,    1'b0, 2,  -1,   0,    1,   0, 0};
        vecs[8]  = '{100,  1'b1, 9,  5,    5,    0,   1, 0};
        vecs[9]  = '{3,    1'b0, 4,  -1,   3,    1,   0, 0};
        vecs[10] = '{4000, 1'b1, 0,  0,    3,    0,   1, 0};
        vecs[11] = '{1009, 1'b1, 0,  -1,   1009, 1,   0, 0};
        vecs[12] = '{3,    1'b0, 0,  -1,   3,    1,   0, 0};

        reset                = 1'b0;
        stop                 = 1'b0;
        cmd_if.cmd_valid     = 1'b0;
        cmd_if.cmd_target    = '0;
        cmd_if.cmd_clockwise = 1'b0;
        cmd_if.step_div      = '0;
        repeat (3) @(posedge CLK);
        #1;

        checkOutput("rst_position", int'(position), 0);
        checkOutput("rst_hall", int'({hall_1, hall_2}), 0);
        checkOutput("rst_ready", int'(cmd_if.cmd_ready), 1);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_pulses", int'({done, aborted, err}), 0);

        // Out-of-range target from position 0, issued on the first edge
        // after reset release.
        reset = 1'b1;
        tv = '{4024, 1'b1, 0, -1, 0, 0, 0, 1};
        applyStimulus(tv, 1'b0);
        checkOutput("err_pulse", int'(err), 1);
        checkOutput("err_ready", int'(cmd_if.cmd_ready), 1);
        checkOutput("err_busy", int'(busy), 0);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("err_hall", int'({hall_1, hall_2}), 0);
        checkOutput("err_count", cnt_err, 1);

        for (int i = 0; i < 13; i++) begin
            runVector(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // stop alongside a command in IDLE is ignored; the move runs.
        tv = '{5, 1'b1, 0, -1, 5, 1, 0, 0};
        runVector(tv, 1'b1, "stop_in_idle");

        // cmd_valid held through a move is taken on the first idle cycle.
        d0  = cnt_done;
        acc = cycle + 1;
        exp_q.push_back('{6, expHall(6), acc + 1});
        exp_q.push_back('{7, expHall(7), acc + 2});
        exp_q.push_back('{6, expHall(6), acc + 4});
        exp_q.push_back('{5, expHall(5), acc + 5});
        cmd_if.cmd_valid     = 1'b1;
        cmd_if.cmd_target    = 12'd7;
        cmd_if.cmd_clockwise = 1'b1;
        cmd_if.step_div      = 16'd0;
        @(posedge CLK); #1;
        cmd_if.cmd_target    = 12'd5;
        cmd_if.cmd_clockwise = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        checkOutput("hold_done_first", int'(done), 1);
        checkOutput("hold_ready", int'(cmd_if.cmd_ready), 1);
        @(posedge CLK); #1;
        cmd_if.cmd_valid = 1'b0;
        checkOutput("hold_busy", int'(busy), 1);
        waitIdle(-1, 0);
        repeat (3) @(posedge CLK);
        #1;
        model_pos = 5;
        checkOutput("hold_pos", int'(position), 5);
        checkOutput("hold_done_count", cnt_done - d0, 2);
        checkOutput("hold_pending", exp_q.size(), 0);

        // Reset in the middle of a move.
        tv = '{100, 1'b1, 0, -1, 100, 1, 0, 0};
        e0 = edges_seen;
        applyStimulus(tv, 1'b0);
        for (int c = 0; c < 300; c++) begin
            if (position == 12'd37) break;
            @(posedge CLK); #1;
        end
        checkOutput("mid_reach37", int'(position), 37);
        d0 = cnt_done;
        a0 = cnt_aborted;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_hall", int'({hall_1, hall_2}), 0);
        checkOutput("mid_rst_pos", int'(position), 0);
        checkOutput("mid_rst_busy", int'(busy), 0);
        checkOutput("mid_rst_ready", int'(cmd_if.cmd_ready), 1);
        exp_q.delete();
        model_pos = 0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b1;
        checkOutput("mid_no_pulse", int'({done, aborted}), 0);
        tv = '{4, 1'b1, 0, -1, 4, 1, 0, 0};
        runVector(tv, 1'b0, "post_reset");
        checkOutput("mid_done_total", cnt_done - d0, 1);
        checkOutput("mid_aborted_total", cnt_aborted - a0, 0);
        checkOutput("mid_edges_moved", (edges_seen - e0 > 0) ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/hall_pattern_generator.md
HALL_PATTERN_GENERATOR -- requirements
Module: hall_pattern_generator

Interface
REQ-001 The block SHALL have parameter COUNTS_PER_REV, default 4024, meaning quadrature edges per revolution (multiple of 4, at most 4096).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: move command present.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: block can accept a command.
REQ-006 The block SHALL have port cmd_target, input, 12 bits: destination position in edge counts.
REQ-007 The block SHALL have port cmd_clockwise, input, 1 bit: 1 = count up (CW), 0 = count down (CCW).
REQ-008 The block SHALL have port step_div, input, 16 bits: edge spacing minus one, in CLK cycles.
REQ-009 The block SHALL have port stop, input, 1 bit: abort the current move.
REQ-010 The block SHALL have ports hall_1 and hall_2, each output, 1 bit: emulated Hall quadrature outputs.
REQ-011 The block SHALL have port position, output, 12 bits: current emulated position.
REQ-012 The block SHALL have ports busy, done, aborted and err, each output, 1 bit: status; done, aborted and err are one-cycle pulses.

Function
REQ-013 The FSM SHALL have states IDLE and RUN; cmd_ready = 1 only in IDLE.
REQ-014 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_target, cmd_clockwise and step_div are latched in that cycle.
REQ-015 If cmd_target >= COUNTS_PER_REV, the block SHALL pulse err in the cycle after acceptance, stay in IDLE and emit no edges.
REQ-016 If cmd_target equals position, the block SHALL pulse done in the cycle after acceptance, stay in IDLE and emit no edges.
REQ-017 Otherwise the FSM SHALL enter RUN with busy=1 and load the step timer with the latched step_div.
REQ-018 In RUN the timer SHALL decrement once per cycle; at 0 it SHALL emit one edge and reload, giving edge spacing step_div+1 cycles (step_div=0 gives one edge per cycle).
REQ-019 The first edge SHALL occur step_div+1 cycles after the accept edge.
REQ-020 Each edge SHALL step position by +1 (CW) or -1 (CCW), wrapping COUNTS_PER_REV-1 to 0 and 0 to COUNTS_PER_REV-1.
REQ-021 {hall_1,hall_2} SHALL be registered from position[1:0]: 0 gives 00, 1 gives 10, 2 gives 11, 3 gives 01; CW therefore has hall_1 leading hall_2, and exactly one output toggles per edge.
REQ-022 When an edge makes position equal to the target, the FSM SHALL return to IDLE and pulse done in the next cycle; cmd_ready rises in that same cycle.
REQ-023 stop=1 in RUN SHALL suppress any edge due in that cycle, return to IDLE and pulse aborted next cycle; position holds its last value.
REQ-024 stop SHALL be ignored in IDLE; simultaneous cmd_valid and stop in IDLE SHALL accept the command.
REQ-025 Commands SHALL NOT be accepted in RUN; cmd_valid held in RUN SHALL be accepted on the first IDLE cycle.

Reset
REQ-026 While reset=0, the block SHALL force: position=0, hall_1=0, hall_2=0, state IDLE, cmd_ready=1, busy=0, done=0, aborted=0, err=0, timer=0.
REQ-027 Reset asserted mid-move SHALL abandon the move without a done or aborted pulse.
REQ-028 The block SHALL leave reset synchronously to CLK and accept commands on the first clock edge after reset release.

Structure
REQ-029 Package hall_pkg SHALL hold the COUNTS_PER_REV default, the state enum (IDLE, RUN) and the position[1:0] to hall-phase encode function, shared with angle_tracking_unit benches.
REQ-030 The step timer (load, decrement, tick) SHALL be sub-module hall_step_timer.
REQ-031 The implementation SHALL contain no latches and no combinational paths from inputs to hall outputs.

Verification
REQ-032 Reset, then cmd target=8, CW, step_div=3 -> 8 edges exactly 4 cycles apart, hall sequence 00,10,11,01,00,...; position=8; one done pulse.
REQ-033 From position 2, cmd target=4022, CCW, step_div=0 -> position wraps 0 to 4023, stops at 4022 after 4 edges; done pulses once.
REQ-034 From position 0, cmd target=4024 -> err pulse, no hall toggles, cmd_ready back high the next cycle.
REQ-035 From position 0, cmd target=100, step_div=9, stop asserted after 5 edges -> aborted pulse, position=5, no further edges, no done.
REQ-036 Reset asserted mid-move at position 37 -> hall=00, position=0, busy=0 immediately; a subsequent target=4 CW move completes normally.
REQ-037 Loopback: outputs drive angle_tracking_unit (monitor=1, clockwise matched); after each move its angle SHALL track position for 1006 CW and 1006 CCW steps.
